// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_I = 1'b0,
        M_D = 1'b1
    } master_t;

    // Instruction fetch always reads a full word.
    localparam logic [3:0] FETCH_BYTEENABLE = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Fetch/data master ports, slave bus and grant status of the memory bus arbiter.
interface mips_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   i_address;
    logic [ADDR_W-1:0]   d_address;
    logic                i_read;
    logic                d_read;
    logic                d_write;
    logic [DATA_W-1:0]   d_writedata;
    logic [DATA_W/8-1:0] d_byteenable;
    logic                i_waitrequest;
    logic                d_waitrequest;
    logic [DATA_W-1:0]   i_readdata;
    logic [DATA_W-1:0]   d_readdata;

    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    logic                grant_i;
    logic                grant_d;

    // CPU side: fetch and load/store units.
    modport master (
        output i_address, d_address, i_read, d_read, d_write, d_writedata, d_byteenable,
        input  i_waitrequest, d_waitrequest, i_readdata, d_readdata, grant_i, grant_d
    );

    // External RAM side.
    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

    modport arbiter (
        input  i_address, d_address, i_read, d_read, d_write, d_writedata, d_byteenable,
        input  waitrequest, readdata,
        output i_waitrequest, d_waitrequest, i_readdata, d_readdata,
        output address, read, write, writedata, byteenable,
        output grant_i, grant_d
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one waitrequest-style memory bus between the
// instruction-fetch and load/store masters; a grant is held until completion.
module mips_bus_arbiter
    import mips_bus_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mips_bus_arbiter_if.arbiter  bus
);

    arb_state_t state_q, state_d;
    master_t    last_q, last_d;
    logic       req_i;
    logic       req_d;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= M_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // waitrequest only reaches the state through the owner's completion term.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req_i && req_d)
                    state_d = (last_q == M_I) ? OWN_D : OWN_I;
                else if (req_i)
                    state_d = OWN_I;
                else if (req_d)
                    state_d = OWN_D;
            end
            OWN_I: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (!bus.waitrequest) begin
                    last_d  = M_I;
                    state_d = req_d ? OWN_D : IDLE;
                end
            end
            OWN_D: begin
                if (!req_d) begin
                    state_d = IDLE;
                end else if (!bus.waitrequest) begin
                    last_d  = M_D;
                    state_d = req_i ? OWN_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.address       = '0;
        bus.read          = 1'b0;
        bus.write         = 1'b0;
        bus.writedata     = '0;
        bus.byteenable    = '0;
        bus.i_waitrequest = 1'b1;
        bus.d_waitrequest = 1'b1;
        bus.grant_i       = 1'b0;
        bus.grant_d       = 1'b0;
        unique case (state_q)
            OWN_I: begin
                bus.grant_i       = 1'b1;
                bus.address       = bus.i_address;
                bus.read          = bus.i_read;
                bus.byteenable    = FETCH_BYTEENABLE;
                bus.i_waitrequest = bus.waitrequest;
            end
            OWN_D: begin
                bus.grant_d       = 1'b1;
                bus.address       = bus.d_address;
                bus.read          = bus.d_read;
                bus.write         = bus.d_write;
                bus.writedata     = bus.d_writedata;
                bus.byteenable    = bus.d_byteenable;
                bus.d_waitrequest = bus.waitrequest;
            end
            default: ;
        endcase
    end

    // Only the owner sees waitrequest low, so fanning readdata out is safe.
    assign bus.i_readdata = bus.readdata;
    assign bus.d_readdata = bus.readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Slave: word RAM indexed by address[9:2], waitrequest under bench control.
    logic [31:0] mem [256];
    logic        slave_wait;
    assign bus.waitrequest = slave_wait;
    assign bus.readdata    = mem[bus.address[9:2]];

    always @(posedge clk) begin
        if (!reset && bus.write && !bus.waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (bus.byteenable[b]) mem[bus.address[9:2]][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {grant_i, grant_d, read, write, i_waitrequest, d_waitrequest}
    function automatic logic [5:0] ctl();
        return {bus.grant_i, bus.grant_d, bus.read, bus.write, bus.i_waitrequest, bus.d_waitrequest};
    endfunction

    task automatic set_req(input logic ir, input logic dr, input logic dw, input logic w);
        bus.i_read  = ir;
        bus.d_read  = dr;
        bus.d_write = dw;
        slave_wait  = w;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic       ir;
        logic       dr;
        logic       dw;
        logic       w;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl [12];

    // Reference model state: owner 0 = none, 1 = fetch, 2 = data.
    int m_owner;
    int m_last;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [5:0]  e_ctl;
        logic        rq_i, rq_d, e_rd, e_wr;
        int          cnt_i, cnt_d, kind;

        for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + 32'(k * 4);
        mem[0]    = 32'h2402_0010;
        mem[8'h40] = 32'hAABB_CCDD;

        tbl[0]  = '{1, 0, 0, 0, 6'b000011};
        tbl[1]  = '{1, 0, 0, 0, 6'b101001};
        tbl[2]  = '{1, 0, 1, 0, 6'b000011};
        tbl[3]  = '{1, 0, 1, 1, 6'b010111};
        tbl[4]  = '{1, 0, 1, 0, 6'b010110};
        tbl[5]  = '{1, 1, 0, 0, 6'b101001};
        tbl[6]  = '{0, 1, 0, 0, 6'b011010};
        tbl[7]  = '{0, 0, 0, 0, 6'b000011};
        tbl[8]  = '{0, 1, 0, 0, 6'b000011};
        tbl[9]  = '{0, 0, 0, 1, 6'b010011};
        tbl[10] = '{1, 1, 0, 0, 6'b000011};
        tbl[11] = '{1, 1, 0, 0, 6'b101001};

        // Reset held two cycles with a pending fetch.
        bus.i_address    = 32'hBFC0_0000;
        bus.d_address    = 32'hBFC0_0100;
        bus.d_writedata  = 32'h0000_0010;
        bus.d_byteenable = 4'b0011;
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("reset_ctl", 64'(ctl()), 64'(6'b000011));
            chk("reset_bus", {bus.address, bus.writedata}, 64'h0);
            chk("reset_be", 64'(bus.byteenable), 64'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        next_cyc();
        @(negedge clk);
        $display("xfer fetch addr=%h data=%h", bus.address, bus.i_readdata);
        chk("fetch_ctl", 64'(ctl()), 64'(6'b101001));
        chk("fetch_addr", 64'(bus.address), 64'hBFC0_0000);
        chk("fetch_rdata", 64'(bus.i_readdata), 64'h2402_0010);
        next_cyc();
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("fetch_bubble", 64'(ctl()), 64'(6'b000011));

        // Simultaneous fetch and half-word store: D wins the first tie.
        next_cyc();
        do_reset();
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("tie_idle", 64'(ctl()), 64'(6'b000011));
        next_cyc();
        @(negedge clk);
        $display("xfer store addr=%h data=%h be=%b", bus.address, bus.writedata, bus.byteenable);
        chk("tie_d_ctl", 64'(ctl()), 64'(6'b010110));
        chk("tie_d_bus", {bus.address, bus.writedata}, {32'hBFC0_0100, 32'h0000_0010});
        chk("tie_d_be", 64'(bus.byteenable), 64'(4'b0011));
        next_cyc();
        bus.d_write = 1'b0;
        @(negedge clk);
        chk("tie_i_next", 64'(ctl()), 64'(6'b101001));
        next_cyc();
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("store_mem", 64'(mem[8'h40]), 64'hAABB_0010);

        // Data read stretched by three wait cycles with fetch pending.
        next_cyc();
        do_reset();
        set_req(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("wait_idle", 64'(ctl()), 64'(6'b000011));
        next_cyc();
        for (int k = 0; k < 4; k++) begin
            slave_wait = (k < 3);
            @(negedge clk);
            chk("wait_hold", 64'(ctl()), 64'({5'b01101, slave_wait}));
            if (k == 3) chk("wait_rdata", 64'(bus.d_readdata), 64'hAABB_0010);
            next_cyc();
        end
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("wait_handover", 64'(ctl()), 64'(6'b101001));

        // Both masters saturating the bus for 20 cycles.
        next_cyc();
        do_reset();
        set_req(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("alt_idle", 64'(ctl()), 64'(6'b000011));
        next_cyc();
        cnt_i = 0;
        cnt_d = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("alt_grant", 64'(ctl()), (k % 2 == 0) ? 64'(6'b011010) : 64'(6'b101001));
            if (bus.grant_i && !bus.i_waitrequest) cnt_i++;
            if (bus.grant_d && !bus.d_waitrequest) cnt_d++;
            next_cyc();
        end
        $display("xfer alternation fetch=%0d data=%0d", cnt_i, cnt_d);
        chk("alt_cnt_i", 64'(cnt_i >= 9 && cnt_i <= 11), 64'h1);
        chk("alt_cnt_d", 64'(cnt_d >= 9 && cnt_d <= 11), 64'h1);

        // Reset in the middle of a stalled store.
        do_reset();
        set_req(1'b1, 1'b0, 1'b1, 1'b1);
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_own_d", 64'(ctl()), 64'(6'b010111));
        next_cyc();
        @(negedge clk);
        chk("mid_reset", 64'(ctl()), 64'(6'b000011));
        reset = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("mid_tie_d", 64'(ctl()), 64'(6'b010111));

        // Vector table applied straight out of reset.
        next_cyc();
        do_reset();
        for (int r = 0; r < 12; r++) begin
            set_req(tbl[r].ir, tbl[r].dr, tbl[r].dw, tbl[r].w);
            @(negedge clk);
            $display("vec %0d ctl=%b", r, ctl());
            chk($sformatf("vec%0d", r), 64'(ctl()), 64'(tbl[r].exp));
            next_cyc();
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_owner = 0;
        m_last  = 1;
        for (int c = 0; c < 300; c++) begin
            kind = int'($urandom_range(0, 2));
            bus.i_read       = ($urandom_range(0, 3) != 0);
            bus.d_read       = (kind == 1);
            bus.d_write      = (kind == 2);
            slave_wait       = ($urandom_range(0, 2) == 0);
            bus.i_address    = 32'hBFC0_0000 | (32'($urandom_range(0, 255)) << 2);
            bus.d_address    = 32'hBFC0_0000 | (32'($urandom_range(0, 255)) << 2);
            bus.d_writedata  = $urandom;
            bus.d_byteenable = 4'($urandom_range(0, 15));
            rq_i = bus.i_read;
            rq_d = bus.d_read | bus.d_write;

            e_addr  = 32'h0;
            e_wdata = 32'h0;
            e_be    = 4'h0;
            e_rd    = 1'b0;
            e_wr    = 1'b0;
            if (m_owner == 1) begin
                e_addr = bus.i_address;
                e_rd   = bus.i_read;
                e_be   = 4'hF;
            end else if (m_owner == 2) begin
                e_addr  = bus.d_address;
                e_rd    = bus.d_read;
                e_wr    = bus.d_write;
                e_wdata = bus.d_writedata;
                e_be    = bus.d_byteenable;
            end
            e_ctl = {m_owner == 1, m_owner == 2, e_rd, e_wr,
                     (m_owner == 1) ? slave_wait : 1'b1,
                     (m_owner == 2) ? slave_wait : 1'b1};

            @(negedge clk);
            chk("rnd_ctl", 64'(ctl()), 64'(e_ctl));
            chk("rnd_bus", {bus.address, bus.writedata}, {e_addr, e_wdata});
            chk("rnd_be", 64'(bus.byteenable), 64'(e_be));
            chk("rnd_rdata", {bus.i_readdata, bus.d_readdata}, {mem[e_addr[9:2]], mem[e_addr[9:2]]});

            if (m_owner == 0) begin
                if (rq_i && rq_d) m_owner = (m_last == 1) ? 2 : 1;
                else if (rq_i)    m_owner = 1;
                else if (rq_d)    m_owner = 2;
            end else if (!((m_owner == 1) ? rq_i : rq_d)) begin
                m_owner = 0;
            end else if (!slave_wait) begin
                $display("xfer cyc=%0d master=%s addr=%h", c, (m_owner == 1) ? "I" : "D", e_addr);
                m_last  = m_owner;
                m_owner = (((m_owner == 1) ? rq_d : rq_i)) ? 3 - m_owner : 0;
            end
            next_cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master round-robin arbiter that shares the single memory bus of `mips_cpu_bus` between the instruction-fetch port and the load/store port of the CPU core. It uses Avalon-style `waitrequest` handshakes on both the master and slave side, and holds each grant until the transfer completes. It sits between the core's fetch and data units and the external RAM, and drives the `address`, `read`, `write`, `writedata` and `byteenable` outputs of `mips_cpu_bus`.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.
- `clk`  in  1  : system clock, all state updates on rising edge.
- `reset`  in  1  : synchronous, active-high.
- `i_address`, `d_address`  in  ADDR_W  : master addresses (i = fetch, d = data).
- `i_read`, `d_read`, `d_write`  in  1  : master requests; fetch is read-only.
- `d_writedata`  in  DATA_W ; `d_byteenable`  in  DATA_W/8 ; fetch byteenable fixed 4'b1111.
- `i_waitrequest`, `d_waitrequest`  out  1  : per-master stall.
- `i_readdata`, `d_readdata`  out  DATA_W  : slave readdata fanned out to both masters.
- `address`  out  ADDR_W ; `read`, `write`  out  1 ; `writedata`  out  DATA_W ; `byteenable`  out  DATA_W/8  : slave side.
- `waitrequest`  in  1 ; `readdata`  in  DATA_W  : slave response.
- `grant_i`, `grant_d`  out  1  : current owner, one-hot or both 0.

## Operation
- States: `IDLE`, `OWN_I`, `OWN_D`. The state is registered, and `grant_*` are decoded from it.
- `req_i = i_read`; `req_d = d_read | d_write`.
- IDLE:
  - Slave `read`/`write` = 0; `address`, `writedata` and `byteenable` are don't-care (drive 0).
  - Both master waitrequests = 1.
  - One request pending: move to its OWN state next cycle.
  - Both pending: grant the master not granted last, tracked by `last` register; reset value of `last` = I, so D wins the first tie.
- OWN_x:
  - Slave outputs are combinationally muxed from master x.
  - `x_waitrequest = waitrequest`; the other master's waitrequest = 1.
  - Completion cycle: `req_x & ~waitrequest`. Master x samples readdata in that cycle; `last <= x`.
  - On completion, if the other master is requesting, go directly to its OWN state; otherwise go to IDLE.
  - Same master back-to-back always passes through IDLE (one bubble cycle), which guarantees fairness.
- Master drops its request while owning (protocol violation): return to IDLE next cycle, `last` unchanged.
- `d_read & d_write` together is illegal; both are forwarded unchanged, and the bench must not drive it.
- `readdata` is passed to both masters unregistered. Only the owner's waitrequest is low, so only the owner consumes it.

## Timing
- Reset:
  - state = IDLE, `last` = I.
  - `read`, `write`, `grant_i`, `grant_d` = 0.
  - `i_waitrequest`, `d_waitrequest` = 1.
  - `address`, `writedata`, `byteenable` = 0.
- Reset asserted mid-transfer: slave request drops on the cycle after the reset edge; the in-flight transfer is abandoned.
- Arbitration latency: request seen in IDLE at edge N, granted from N+1. The earliest completion is cycle N+1 with a zero-wait slave.
- Minimum occupancy is 1 cycle per transfer. Alternating masters sustain 1 transfer per cycle; a single master alone gets 1 transfer per 2 cycles.
- The grant never changes while `waitrequest` = 1 and the owner is requesting.
- No combinational path from `waitrequest` to state except through the completion term.

## Structure
- Package `mips_bus_pkg` holds:
  - `arb_state_t` enum (IDLE, OWN_I, OWN_D);
  - `master_t` enum (M_I, M_D);
  - constant `FETCH_BYTEENABLE` = 4'b1111.
- Single flat module. The output mux is an always_comb block keyed on state; no sub-module is needed.

## Test plan
- Reset held 2 cycles with `i_read` = 1:
  - all outputs equal their reset values, with `i_waitrequest` = 1;
  - `grant_i` = 1 on the first cycle after reset deasserts.
- Fetch alone, `i_address` = 0xBFC00000, slave zero-wait returning 0x24020010:
  - `read` = 1 and `address` = 0xBFC00000 one cycle after request;
  - `i_readdata` = 0x24020010 while `i_waitrequest` = 0;
  - IDLE for one cycle afterwards.
- Simultaneous `i_read` and `d_write` (0xBFC00100, 0x00000010, byteenable 4'b0011) from reset:
  - D granted first, fetch granted in the cycle immediately after D completes;
  - memory word at 0xBFC00100 lower half becomes 0x0010.
- Slave holds `waitrequest` = 1 for 3 cycles during a D read:
  - `grant_d` is stable all 4 cycles and `i_waitrequest` stays 1;
  - completion occurs on the 4th cycle.
- Both masters request continuously for 20 cycles:
  - grants strictly alternate I/D;
  - each master completes 10 ±1 transfers, with no bubbles.
- Reset asserted during OWN_D with `waitrequest` = 1:
  - the next cycle shows `write` = 0 and state IDLE;
  - after release, D wins the first tie again.
